matrix_loader_p: RTL and testbench
==================================

Name: matrix_loader_p

Overview:
- Parametrised successor to the fixed 2x2 matrix loader. Accepts a serial nibble/word stream over a valid/ready handshake: a 4-word dimension header (R1, C1, R2, C2), then matrix 1 and matrix 2 elements in row-major order.
- Stores both operands of up to MAX_DIM x MAX_DIM, validates the dimensions, and reports load status and errors.
- Provides a registered read port for the downstream multiply datapath.

Parameters:
- DATA_W, 4, element and header word width in bits.
- MAX_DIM, 2, maximum rows or columns per matrix.
- DIM_W, $clog2(MAX_DIM+1), dimension field width. Requires DATA_W >= DIM_W.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- in_data  in  DATA_W  header word or element.
- in_hdr  in  1  1 = header word, 0 = matrix element.
- in_valid  in  1  source has a word.
- in_ready  out  1  block accepts a word this cycle.
- R1, C1, R2, C2  out  DIM_W each  captured dimensions.
- loaded  out  1  both matrices fully stored.
- err  out  1  load failed.
- err_code  out  2  0 none, 1 bad dimension, 2 incompatible, 3 protocol.
- rd_sel  in  1  0 = matrix 1, 1 = matrix 2.
- rd_row, rd_col  in  DIM_W each  element index.
- rd_data  out  DATA_W  registered element.

Behaviour:
- Beat = in_valid && in_ready, sampled on the CLK rising edge.
- Header words use in_data[DIM_W-1:0]. Upper bits are ignored.
- States:
  - HDR: hdr_cnt 0..3, in_ready=1.
  - CHK: one cycle, in_ready=0.
  - M1, M2: in_ready=1.
  - DONE, ERR: in_ready=1.
- HDR:
  - Beat with in_hdr=1 stores the word into R1/C1/R2/C2 by hdr_cnt. After the 4th word, go to CHK.
  - Beat with in_hdr=0 at hdr_cnt=0 is dropped silently.
  - Beat with in_hdr=0 at hdr_cnt>0 goes to ERR, code 3.
- CHK:
  - Any dimension 0 or > MAX_DIM goes to ERR, code 1.
  - Otherwise the compatibility check applies (see Optional Feature).
  - Otherwise go to M1 with row=col=0.
- M1/M2 element handling:
  - Beat with in_hdr=0 writes element (row,col) at address row*MAX_DIM+col of the selected array.
  - col increments and wraps at C1 (M1) or C2 (M2); on wrap, row increments.
  - The write of (R1-1, C1-1) moves to M2 with counters cleared.
  - The write of (R2-1, C2-1) moves to DONE; loaded=1 in the following cycle.
- M1/M2 beat with in_hdr=1 goes to ERR, code 3; the word is discarded.
- DONE/ERR:
  - Beat with in_hdr=0 is dropped; loaded, err and err_code hold.
  - Beat with in_hdr=1 restarts: the word is captured as R1, hdr_cnt=1, state HDR, and loaded, err and err_code clear the same edge.
- err=1 whenever the state is ERR. err_code holds until restart or reset.
- Reset, including mid-load:
  - State HDR, hdr_cnt=0, row/col=0.
  - R1..C2=0, loaded=0, err=0, err_code=0, rd_data=0, both arrays cleared to 0.
  - in_ready=1 from the first cycle after reset.
- Read port:
  - 1-cycle latency; rd_data reflects the rd_sel/rd_row/rd_col values sampled on the previous edge.
  - Returns 0 if rd_row or rd_col >= the selected matrix's captured dimensions.
  - Reads are legal in any state. A read and a write to the same location on the same edge return the old value.
- in_valid with in_ready=0 (CHK) is not consumed; the source must hold the word.

Optional Feature:
- MATRIX_LOADER_COMPAT_CHK_EN.
- Defined: CHK also requires C1 == R2; a mismatch goes to ERR, code 2.
- Undefined: no C1/R2 check, so element-wise operand pairs load; code 2 is never produced.

Test Plan:
- DATA_W=4, MAX_DIM=2: header 2,2,2,2 then elements 1,15,2,2,1,15,2,2 -> loaded=1, err=0. Reads of M1 (0,0)=1, (0,1)=15, (1,0)=2, (1,1)=2; M2 identical.
- MAX_DIM=4: header 2,3,3,1; M1 elements 1..6, M2 elements 7..9, in_valid toggled every other cycle -> loaded=1. M1(1,2)=6, M2(2,0)=9, M1(2,0)=0 (out of range).
- Header 0,2,2,2 -> err=1, err_code=1, loaded=0. A following in_hdr=1 beat clears err and restarts.
- Macro defined, header 2,2,3,2 -> err_code=2. Macro undefined, same header -> loads normally after 4+6 elements.
- Protocol: in_hdr=1 beat after 2 elements of M1 -> err_code=3. in_hdr=0 after 2 header words -> err_code=3.
- RST asserted for 1 cycle after 3 elements of M1 -> R1..C2=0, loaded=0, all reads return 0. A full reload afterwards succeeds.

Source files
------------

// File: rtl/matrix_loader_p.sv
// rtl/matrix_loader_p.sv - parametrised two-operand matrix loader with dimension checks and registered read port
// Optional feature macro: MATRIX_LOADER_COMPAT_CHK_EN (when defined, C1 must equal R2; mismatch reports error code 2)
module matrix_loader_p #(
  parameter int DATA_W  = 4,
  parameter int MAX_DIM = 2,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_hdr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DIM_W-1:0]  R1,
  output logic [DIM_W-1:0]  C1,
  output logic [DIM_W-1:0]  R2,
  output logic [DIM_W-1:0]  C2,
  output logic              loaded,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              rd_sel,
  input  logic [DIM_W-1:0]  rd_row,
  input  logic [DIM_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH  = MAX_DIM * MAX_DIM;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  typedef enum logic [2:0] {S_HDR, S_CHK, S_M1, S_M2, S_DONE, S_ERR} state_t;

  state_t              state;
  state_t              state_nx;
  logic [1:0]          hdr_cnt;
  logic [DIM_W-1:0]    row;
  logic [DIM_W-1:0]    col;
  logic [DATA_W-1:0]   mem1 [DEPTH];
  logic [DATA_W-1:0]   mem2 [DEPTH];

  logic                beat;
  logic                restart;
  logic                err_set;
  logic [1:0]          code_nx;
  logic                dim_bad;
  logic [DIM_W-1:0]    hdr_word;
  logic [DIM_W-1:0]    cur_r;
  logic [DIM_W-1:0]    cur_c;
  logic                last_col;
  logic                last_row;
  logic                last_elem;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DIM_W-1:0]    rd_dr;
  logic [DIM_W-1:0]    rd_dc;
  logic                rd_ok;
  logic [ADDR_W-1:0]   rd_addr;
  logic                unused_hdr_bits;

  // Header words carry the dimension in the low bits; the rest of the word is don't-care.
  assign hdr_word        = in_data[DIM_W-1:0];
  assign unused_hdr_bits = ^in_data;

  assign beat    = in_valid && in_ready;
  assign restart = beat && in_hdr && ((state == S_DONE) || (state == S_ERR));

  assign dim_bad = (R1 == '0) || (R1 > MAX_D) || (C1 == '0) || (C1 > MAX_D) ||
                   (R2 == '0) || (R2 > MAX_D) || (C2 == '0) || (C2 > MAX_D);

  // Element counters walk the active matrix in row-major order.
  assign cur_r     = (state == S_M2) ? R2 : R1;
  assign cur_c     = (state == S_M2) ? C2 : C1;
  assign last_col  = (col == cur_c - ONE_D);
  assign last_row  = (row == cur_r - ONE_D);
  assign last_elem = last_col && last_row;
  assign wr_addr   = ADDR_W'(row) * ADDR_W'(MAX_DIM) + ADDR_W'(col);

  // Reads outside the captured dimensions (or the physical array) return zero.
  assign rd_dr   = rd_sel ? R2 : R1;
  assign rd_dc   = rd_sel ? C2 : C1;
  assign rd_ok   = (rd_row < rd_dr) && (rd_col < rd_dc) && (rd_row < MAX_D) && (rd_col < MAX_D);
  assign rd_addr = ADDR_W'(rd_row) * ADDR_W'(MAX_DIM) + ADDR_W'(rd_col);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_HDR;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode, including which error code to latch on entry to ERR.
  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    code_nx  = 2'd0;
    case (state)
      S_HDR: begin
        if (beat) begin
          if (in_hdr) begin
            if (hdr_cnt == 2'd3) begin
              state_nx = S_CHK;
            end
          end else if (hdr_cnt != 2'd0) begin
            state_nx = S_ERR;
            err_set  = 1'b1;
            code_nx  = 2'd3;
          end
        end
      end
      S_CHK: begin
        if (dim_bad) begin
          state_nx = S_ERR;
          err_set  = 1'b1;
          code_nx  = 2'd1;
        end
`ifdef MATRIX_LOADER_COMPAT_CHK_EN
        else if (C1 != R2) begin
          state_nx = S_ERR;
          err_set  = 1'b1;
          code_nx  = 2'd2;
        end
`endif
        else begin
          state_nx = S_M1;
        end
      end
      S_M1, S_M2: begin
        if (beat) begin
          if (in_hdr) begin
            state_nx = S_ERR;
            err_set  = 1'b1;
            code_nx  = 2'd3;
          end else if (last_elem) begin
            state_nx = (state == S_M1) ? S_M2 : S_DONE;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_nx = S_HDR;
        end
      end
      default: state_nx = S_HDR;
    endcase
  end

  // Handshake and status outputs are pure functions of the state.
  always_comb begin
    in_ready = (state != S_CHK);
    loaded   = (state == S_DONE);
    err      = (state == S_ERR);
  end

  // Header capture, element counters and sticky error code.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hdr_cnt  <= 2'd0;
      row      <= '0;
      col      <= '0;
      R1       <= '0;
      C1       <= '0;
      R2       <= '0;
      C2       <= '0;
      err_code <= 2'd0;
    end else begin
      if (err_set) begin
        err_code <= code_nx;
      end else if (restart) begin
        err_code <= 2'd0;
      end
      case (state)
        S_HDR: begin
          if (beat && in_hdr) begin
            case (hdr_cnt)
              2'd0:    R1 <= hdr_word;
              2'd1:    C1 <= hdr_word;
              2'd2:    R2 <= hdr_word;
              default: C2 <= hdr_word;
            endcase
            hdr_cnt <= hdr_cnt + 2'd1;
          end
        end
        S_CHK: begin
          row <= '0;
          col <= '0;
        end
        S_M1, S_M2: begin
          if (beat && !in_hdr) begin
            if (last_col) begin
              col <= '0;
              row <= last_row ? '0 : row + ONE_D;
            end else begin
              col <= col + ONE_D;
            end
          end
        end
        default: begin
          if (restart) begin
            R1      <= hdr_word;
            hdr_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

  // Operand storage and registered read port; a same-edge read sees the pre-write value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if ((state == S_M1) && beat && !in_hdr) begin
        mem1[wr_addr] <= in_data;
      end
      if ((state == S_M2) && beat && !in_hdr) begin
        mem2[wr_addr] <= in_data;
      end
      rd_data <= rd_ok ? (rd_sel ? mem2[rd_addr] : mem1[rd_addr]) : '0;
    end
  end

endmodule

// File: tb/tb_matrix_loader_p.sv
// tb/tb_matrix_loader_p.sv - self-checking bench for matrix_loader_p (DATA_W=4, MAX_DIM=4)
module tb_matrix_loader_p;

  localparam int DATA_W  = 4;
  localparam int MAX_DIM = 4;
  localparam int DIM_W   = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_hdr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DIM_W-1:0]  R1, C1, R2, C2;
  logic              loaded;
  logic              err;
  logic [1:0]        err_code;
  logic              rd_sel = 1'b0;
  logic [DIM_W-1:0]  rd_row = '0;
  logic [DIM_W-1:0]  rd_col = '0;
  logic [DATA_W-1:0] rd_data;

  always #5 CLK = ~CLK;

  matrix_loader_p #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
    .in_ready(in_ready), .R1(R1), .C1(C1), .R2(R2), .C2(C2), .loaded(loaded),
    .err(err), .err_code(err_code), .rd_sel(rd_sel), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int mh[4];
  int mnh = 0;
  bit mchk = 1'b0;
  bit mloaded = 1'b0;
  bit merr = 1'b0;
  int mcode = 0;
  int mk = 0;
  int mm[2][MAX_DIM][MAX_DIM];
  int mrd = 0;

  typedef struct {
    bit rst; bit v; bit h; int d; bit s; int r; int c;
    bit e_rdy; bit e_ld; bit e_err; int e_code; bit chk_rd; int e_rd;
  } vec_t;
  vec_t tbl[$];

  typedef struct { bit h; int d; } word_t;
  word_t gq[$];

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int s, r, c, dr, dc, t1, j, w;
    if (RST) begin
      mrd = 0; mnh = 0; mchk = 0; mloaded = 0; merr = 0; mcode = 0; mk = 0;
      foreach (mh[i]) mh[i] = 0;
      foreach (mm[a, b, e]) mm[a][b][e] = 0;
      return;
    end
    s = int'(rd_sel); r = int'(rd_row); c = int'(rd_col);
    dr = s ? mh[2] : mh[0];
    dc = s ? mh[3] : mh[1];
    mrd = 0;
    if (r < dr && c < dc && r < MAX_DIM && c < MAX_DIM) mrd = mm[s][r][c];
    w = int'(in_data) % (1 << DIM_W);
    if (mchk) begin
      mchk = 0;
      if (mh[0] == 0 || mh[0] > MAX_DIM || mh[1] == 0 || mh[1] > MAX_DIM ||
          mh[2] == 0 || mh[2] > MAX_DIM || mh[3] == 0 || mh[3] > MAX_DIM) begin
        merr = 1; mcode = 1;
      end
`ifdef MATRIX_LOADER_COMPAT_CHK_EN
      else if (mh[1] != mh[2]) begin
        merr = 1; mcode = 2;
      end
`endif
      else begin
        mk = 0;
      end
    end else if (in_valid) begin
      if (merr || mloaded) begin
        if (in_hdr) begin
          merr = 0; mloaded = 0; mcode = 0; mh[0] = w; mnh = 1;
        end
      end else if (mnh < 4) begin
        if (in_hdr) begin
          mh[mnh] = w; mnh++;
          if (mnh == 4) mchk = 1;
        end else if (mnh > 0) begin
          merr = 1; mcode = 3;
        end
      end else begin
        if (in_hdr) begin
          merr = 1; mcode = 3;
        end else begin
          t1 = mh[0] * mh[1];
          if (mk < t1) mm[0][mk / mh[1]][mk % mh[1]] = int'(in_data);
          else begin
            j = mk - t1;
            mm[1][j / mh[3]][j % mh[3]] = int'(in_data);
          end
          mk++;
          if (mk == t1 + mh[2] * mh[3]) mloaded = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready", int'(in_ready), int'(!mchk));
    chk("loaded", int'(loaded), int'(mloaded));
    chk("err", int'(err), int'(merr));
    chk("err_code", int'(err_code), mcode);
    chk("R1", int'(R1), mh[0]);
    chk("C1", int'(C1), mh[1]);
    chk("R2", int'(R2), mh[2]);
    chk("C2", int'(C2), mh[3]);
    chk("rd_data", int'(rd_data), mrd);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
    @(negedge CLK);
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    cycle();
    RST = 1'b0;
  endtask

  task automatic send(bit h, int d);
    int guard = 0;
    in_valid = 1'b1;
    in_hdr = h;
    in_data = DATA_W'(d);
    while (!in_ready && guard < 8) begin
      cycle();
      guard++;
    end
    if (guard >= 8) chk("send_timeout", 0, 1);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic rd(bit s, int r, int c, output int v);
    in_valid = 1'b0;
    rd_sel = s;
    rd_row = DIM_W'(r);
    rd_col = DIM_W'(c);
    cycle();
    v = int'(rd_data);
  endtask

  task automatic load(int r1, int c1, int r2, int c2, int base, bit tog);
    int n;
    int dims[4];
    n = r1 * c1 + r2 * c2;
    dims = '{r1, c1, r2, c2};
    for (int i = 0; i < 4; i++) begin
      if (tog) idle(1);
      send(1'b1, dims[i]);
    end
    for (int i = 0; i < n; i++) begin
      if (tog) idle(1);
      send(1'b0, (base + i) % 16);
    end
  endtask

  task automatic gen_load();
    int d[4];
    int n;
    for (int i = 0; i < 4; i++) begin
      d[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, MAX_DIM));
      gq.push_back('{1'b1, d[i]});
    end
    n = d[0] * d[1] + d[2] * d[3];
    for (int i = 0; i < n; i++) gq.push_back('{($urandom_range(0, 39) == 0), int'($urandom_range(0, 15))});
    if ($urandom_range(0, 3) == 0) gq.push_back('{1'b0, int'($urandom_range(0, 15))});
  endtask

  function automatic void add(bit rst, bit v, bit h, int d, bit s, int r, int c,
                              bit erdy, bit eld, bit eerr, int ecode, bit crd, int erd);
    tbl.push_back('{rst, v, h, d, s, r, c, erdy, eld, eerr, ecode, crd, erd});
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    bit took;

    //   rst v  h  d   s  r  c  rdy ld er code crd rd
    add(1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 15, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 15, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2,  0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0, 1, 15);
    add(0, 0, 0, 0,  0, 1, 0, 1, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0,  0, 1, 1, 1, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0,  1, 0, 1, 1, 1, 0, 0, 1, 15);
    add(0, 0, 0, 0,  1, 1, 1, 1, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0,  0, 2, 0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 1, 2,  0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 1, 0, 3,  0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 1, 1, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      RST = tbl[i].rst;
      in_valid = tbl[i].v;
      in_hdr = tbl[i].h;
      in_data = DATA_W'(tbl[i].d);
      rd_sel = tbl[i].s;
      rd_row = DIM_W'(tbl[i].r);
      rd_col = DIM_W'(tbl[i].c);
      cycle();
      chk($sformatf("tbl%0d_rdy", i), int'(in_ready), int'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_ld", i), int'(loaded), int'(tbl[i].e_ld));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e_err));
      chk($sformatf("tbl%0d_code", i), int'(err_code), tbl[i].e_code);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), int'(rd_data), tbl[i].e_rd);
    end
    RST = 1'b0;

    // 2x3 by 3x1 with gaps between words
    do_reset();
    load(2, 3, 3, 1, 1, 1'b1);
    chk("t2_loaded", int'(loaded), 1);
    rd(1'b0, 1, 2, v); chk("t2_m1_12", v, 6);
    rd(1'b1, 2, 0, v); chk("t2_m2_20", v, 9);
    rd(1'b0, 2, 0, v); chk("t2_m1_20_oor", v, 0);

    // Dimension boundary: 5 exceeds MAX_DIM
    do_reset();
    load(4, 4, 4, 5, 0, 1'b0);
    idle(1);
    chk("dim5_err", int'(err), 1);
    chk("dim5_code", int'(err_code), 1);

    // Non-matching inner dimensions
    do_reset();
`ifdef MATRIX_LOADER_COMPAT_CHK_EN
    load(2, 2, 3, 2, 1, 1'b0);
    idle(1);
    chk("compat_err", int'(err), 1);
    chk("compat_code", int'(err_code), 2);
`else
    load(2, 2, 3, 2, 1, 1'b0);
    chk("compat_loaded", int'(loaded), 1);
    chk("compat_err", int'(err), 0);
    rd(1'b1, 2, 1, v); chk("compat_m2_21", v, 10);
`endif

    // Protocol errors
    do_reset();
    load(2, 2, 2, 2, 0, 1'b0);
    do_reset();
    send(1'b1, 2); send(1'b1, 2); send(1'b1, 2); send(1'b1, 2);
    send(1'b0, 1); send(1'b0, 2);
    send(1'b1, 7);
    chk("proto_m1_err", int'(err), 1);
    chk("proto_m1_code", int'(err_code), 3);
    chk("proto_m1_r1", int'(R1), 2);
    send(1'b1, 2);
    chk("proto_restart_err", int'(err), 0);
    send(1'b1, 2);
    send(1'b0, 5);
    chk("proto_hdr_err", int'(err), 1);
    chk("proto_hdr_code", int'(err_code), 3);

    // Reset in the middle of matrix 1
    do_reset();
    send(1'b1, 2); send(1'b1, 2); send(1'b1, 2); send(1'b1, 2);
    send(1'b0, 1); send(1'b0, 2); send(1'b0, 3);
    do_reset();
    chk("rst_R1", int'(R1), 0);
    chk("rst_C1", int'(C1), 0);
    chk("rst_R2", int'(R2), 0);
    chk("rst_C2", int'(C2), 0);
    chk("rst_loaded", int'(loaded), 0);
    rd(1'b0, 0, 0, v); chk("rst_rd00", v, 0);
    rd(1'b0, 0, 1, v); chk("rst_rd01", v, 0);
    send(1'b1, 2); send(1'b1, 2); send(1'b1, 2); send(1'b1, 2);
    rd(1'b0, 0, 1, v); chk("rst_cleared01", v, 0);
    for (int i = 0; i < 8; i++) send(1'b0, 4 + i);
    chk("reload_loaded", int'(loaded), 1);
    rd(1'b0, 0, 1, v); chk("reload_m1_01", v, 5);
    rd(1'b1, 1, 1, v); chk("reload_m2_11", v, 11);

    // Randomised streams against the model
    do_reset();
    gq.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (gq.size() == 0) gen_load();
      RST = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_hdr = gq[0].h;
      in_data = DATA_W'(gq[0].d);
      rd_sel = 1'($urandom_range(0, 1));
      rd_row = DIM_W'($urandom_range(0, 7));
      rd_col = DIM_W'($urandom_range(0, 7));
      took = in_valid && !mchk && !RST;
      cycle();
      if (took) void'(gq.pop_front());
    end
    RST = 1'b0;
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
